misao_mem_bridge: RTL and testbench

Nibble-to-byte memory bridge between the MISA-O core's 4-bit memory port and a byte-wide synchronous RAM. The core addresses nibbles (16-bit address, 4-bit data); the bridge maps each nibble address to a byte address plus half select. It serves reads from a one-byte holding buffer and performs writes as write-through byte merges, using read-modify-write on a miss. It drives the core's read/write enables, stalling the core while the RAM is busy.

---
 rtl/misao_mem_bridge_pkg.sv | 28 ++
 rtl/misao_mem_bridge_if.sv | 39 +++
 rtl/misao_mem_bridge.sv | 132 +++++++++++++
 tb/tb_misao_mem_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/misao_mem_bridge_pkg.sv
// Shared types and helpers for the MISA-O nibble-to-byte memory bridge.
// Contents:
//   bridge_state_t  bridge FSM state encoding
//   NIB_LO/NIB_HI   half-select values (nibble address bit 0)
//   nib_merge       replaces one half of a byte, keeping the other half
package misao_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        RMW_FILL = 2'd2,
        WRITE    = 2'd3
    } bridge_state_t;

    localparam logic NIB_LO = 1'b0;
    localparam logic NIB_HI = 1'b1;

    function automatic logic [7:0] nib_merge(input logic [7:0] byte_in,
                                             input logic [3:0] nib,
                                             input logic       half);
        logic [7:0] res;
        res = byte_in;
        if (half == NIB_HI) res[7:4] = nib;
        else                res[3:0] = nib;
        return res;
    endfunction

endpackage

// File: rtl/misao_mem_bridge_if.sv
// Bus bundle for the memory bridge: the core-side nibble port and the
// RAM-side byte port.
//   master : the environment (MISA-O core + byte RAM)
//   slave  : the bridge
// Core side: cpu_addr, cpu_rw, cpu_wdata -> bridge; cpu_rdata, cpu_rd_en,
//            cpu_wr_en -> core.
// RAM side:  ram_addr, ram_en, ram_we, ram_wdata -> RAM; ram_rdata,
//            ram_ready -> bridge.
interface misao_mem_bridge_if #(parameter int ADDR_W = 16);

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rw;
    logic [3:0]        cpu_wdata;
    logic [3:0]        cpu_rdata;
    logic              cpu_rd_en;
    logic              cpu_wr_en;

    logic [ADDR_W-2:0] ram_addr;
    logic              ram_en;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              ram_ready;

    modport master (
        output cpu_addr, cpu_rw, cpu_wdata,
        input  cpu_rdata, cpu_rd_en, cpu_wr_en,
        input  ram_addr, ram_en, ram_we, ram_wdata,
        output ram_rdata, ram_ready
    );

    modport slave (
        input  cpu_addr, cpu_rw, cpu_wdata,
        output cpu_rdata, cpu_rd_en, cpu_wr_en,
        output ram_addr, ram_en, ram_we, ram_wdata,
        input  ram_rdata, ram_ready
    );

endinterface

// File: rtl/misao_mem_bridge.sv
// Nibble-to-byte memory bridge between the MISA-O 4-bit memory port and a
// byte-wide synchronous RAM. Reads are served from a one-byte holding
// buffer; writes are write-through byte merges (read-modify-write on miss).
// Ports:
//   clk      clock, all state on rising edge
//   rst      synchronous active-low reset
//   flush    invalidate the holding buffer
//   wr_drop  sticky: a write arrived while the bridge was busy
//   bus      core/RAM bus bundle (slave view)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | serving hits; accepts writes; starts fills on read miss
// FILL     | RAM read outstanding for a read miss
// RMW_FILL | RAM read outstanding for a write miss (merge on return)
// WRITE    | RAM write of the merged byte outstanding
module misao_mem_bridge
    import misao_mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    output logic                wr_drop,
    misao_mem_bridge_if.slave   bus
);

    bridge_state_t     state;
    logic [7:0]        buf_data;
    logic [ADDR_W-2:0] buf_addr;
    logic              buf_valid;
    logic [3:0]        wr_nib;
    logic              wr_half;

    logic [ADDR_W-2:0] byte_addr;
    logic              half;
    logic              hit;

    assign byte_addr = bus.cpu_addr[ADDR_W-1:1];
    assign half      = bus.cpu_addr[0];
    assign hit       = buf_valid && (buf_addr == byte_addr);

    always_comb begin
        bus.cpu_rdata = 4'h0;
        bus.cpu_rd_en = 1'b0;
        bus.cpu_wr_en = 1'b0;
        if (rst) begin
            bus.cpu_rdata = (half == NIB_HI) ? buf_data[7:4] : buf_data[3:0];
            bus.cpu_rd_en = (state == IDLE) && bus.cpu_rw && hit;
            bus.cpu_wr_en = (state == IDLE) && !bus.cpu_rw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            buf_data      <= 8'h00;
            buf_addr      <= '0;
            buf_valid     <= 1'b0;
            wr_nib        <= 4'h0;
            wr_half       <= NIB_LO;
            wr_drop       <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_rw) begin
                        if (!hit) begin
                            bus.ram_en   <= 1'b1;
                            bus.ram_we   <= 1'b0;
                            bus.ram_addr <= byte_addr;
                            state        <= FILL;
                        end
                    end else begin
                        wr_nib  <= bus.cpu_wdata;
                        wr_half <= half;
                        bus.ram_addr <= byte_addr;
                        bus.ram_en   <= 1'b1;
                        if (hit) begin
                            buf_data      <= nib_merge(buf_data, bus.cpu_wdata, half);
                            bus.ram_wdata <= nib_merge(buf_data, bus.cpu_wdata, half);
                            bus.ram_we    <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            bus.ram_we <= 1'b0;
                            state      <= RMW_FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.ram_ready) begin
                        buf_data   <= bus.ram_rdata;
                        buf_addr   <= bus.ram_addr;
                        buf_valid  <= 1'b1;
                        bus.ram_en <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RMW_FILL: begin
                    // ram_en stays high: the read completion directly
                    // becomes the write of the merged byte.
                    if (bus.ram_ready) begin
                        buf_data      <= nib_merge(bus.ram_rdata, wr_nib, wr_half);
                        buf_addr      <= bus.ram_addr;
                        buf_valid     <= 1'b1;
                        bus.ram_wdata <= nib_merge(bus.ram_rdata, wr_nib, wr_half);
                        bus.ram_we    <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.ram_ready) begin
                        bus.ram_en <= 1'b0;
                        bus.ram_we <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if ((state != IDLE) && !bus.cpu_rw) wr_drop <= 1'b1;

            // Placed last so it overrides a fill completion on the same edge.
            if (flush) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_misao_mem_bridge.sv
module tb_misao_mem_bridge;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic wr_drop;

    misao_mem_bridge_if #(.ADDR_W(16)) bus ();

    misao_mem_bridge #(.ADDR_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_drop (wr_drop),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [7:0] mem [0:32767];
    int ram_lat  = 0;
    int wait_cnt = 0;

    assign bus.ram_rdata = mem[bus.ram_addr];

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_ready) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            wait_cnt <= 0;
        end else if (bus.ram_en) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    always @(negedge clk) bus.ram_ready = bus.ram_en && (wait_cnt >= ram_lat);

    // ram_en cycle counter and address-stability monitor
    int          en_cycles  = 0;
    int          addr_glitch = 0;
    logic        en_prev    = 1'b0;
    logic [14:0] addr_prev  = '0;

    always @(negedge clk) begin
        if (bus.ram_en) begin
            en_cycles = en_cycles + 1;
            if (en_prev && bus.ram_addr != addr_prev) addr_glitch = addr_glitch + 1;
        end
        en_prev   = bus.ram_en;
        addr_prev = bus.ram_addr;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns at the falling edge of the
    // cycle in which cpu_rd_en is seen, counting the cycles waited.
    task automatic wait_rd(output int cycles, output logic ok);
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.cpu_rd_en) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                cycles++;
            end
        end
    endtask

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [3:0]  wdata;
        int          lat;
        int          exp_cycles;
        int          exp_en;
        logic [3:0]  exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic run_vec(input int idx, input vec_t v);
        int   c;
        int   cyc;
        logic ok;
        logic [3:0] exp;
        ram_lat   = v.lat;
        en_cycles = 0;
        bus.cpu_addr  = v.addr;
        bus.cpu_rw    = v.rw;
        bus.cpu_wdata = v.wdata;
        sb.push_back(v.exp_rdata);
        cyc = 0;
        if (!v.rw) begin
            @(negedge clk);
            chk($sformatf("vec%0d wr_en", idx), {31'b0, bus.cpu_wr_en}, 32'd1);
            @(posedge clk); #1;
            bus.cpu_rw = 1'b1;
            cyc = 1;
        end
        wait_rd(c, ok);
        cyc += c;
        exp = sb.pop_front();
        if (!ok) begin
            chk($sformatf("vec%0d rd_en timeout", idx), 32'd0, 32'd1);
        end else begin
            chk($sformatf("vec%0d rdata", idx), {28'b0, bus.cpu_rdata}, {28'b0, exp});
            chk($sformatf("vec%0d cycles", idx), cyc, v.exp_cycles);
            chk($sformatf("vec%0d ram_en cycles", idx), en_cycles, v.exp_en);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int   c;
        logic ok;

        for (int i = 0; i < 32768; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0]       = 8'hA5;
        mem[8]       = 8'hC7;
        mem[15'h7FFF] = 8'h9B;

        //          rw    addr      wd    lat cyc en  rdata
        vecs[0]  = '{1'b1, 16'h0000, 4'h0, 0, 2, 1, 4'h5}; // miss fill
        vecs[1]  = '{1'b1, 16'h0001, 4'h0, 0, 0, 0, 4'hA}; // hit high half
        vecs[2]  = '{1'b0, 16'h0001, 4'h3, 0, 2, 1, 4'h3}; // write hit -> 0x35
        vecs[3]  = '{1'b1, 16'h0000, 4'h0, 0, 0, 0, 4'h5}; // other half intact
        vecs[4]  = '{1'b0, 16'h0010, 4'hE, 0, 3, 2, 4'hE}; // write miss C7->CE
        vecs[5]  = '{1'b1, 16'h0011, 4'h0, 0, 0, 0, 4'hC};
        vecs[6]  = '{1'b1, 16'h0001, 4'h0, 0, 2, 1, 4'h3}; // write-through reached RAM
        vecs[7]  = '{1'b1, 16'hFFFF, 4'h0, 3, 5, 4, 4'h9}; // wrap + 3 wait states
        vecs[8]  = '{1'b1, 16'hFFFE, 4'h0, 0, 0, 0, 4'hB};
        vecs[9]  = '{1'b0, 16'hFFFE, 4'h1, 0, 2, 1, 4'h1}; // 9B -> 91
        vecs[10] = '{1'b1, 16'h0011, 4'h0, 1, 3, 2, 4'hC};
        vecs[11] = '{1'b0, 16'h1235, 4'h7, 2, 7, 6, 4'h7}; // 40 -> 70, waits
        vecs[12] = '{1'b1, 16'h1234, 4'h0, 0, 0, 0, 4'h0};

        // ---- reset: outputs forced low even with a write presented ----
        rst = 1'b0;
        flush = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_rw = 1'b0;
        bus.cpu_wdata = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset wr_en", {31'b0, bus.cpu_wr_en}, 32'd0);
        chk("reset rd_en", {31'b0, bus.cpu_rd_en}, 32'd0);
        chk("reset rdata", {28'b0, bus.cpu_rdata}, 32'd0);
        chk("reset ram_en", {31'b0, bus.ram_en}, 32'd0);
        chk("reset wr_drop", {31'b0, wr_drop}, 32'd0);
        @(posedge clk); #1;
        bus.cpu_rw = 1'b1;
        rst = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
        chk("ram byte 0x000", {24'b0, mem[0]}, 32'h35);
        chk("ram byte 0x008", {24'b0, mem[8]}, 32'hCE);
        chk("ram byte 0x7FFF", {24'b0, mem[15'h7FFF]}, 32'h91);
        chk("ram byte 0x91A", {24'b0, mem[15'h091A]}, 32'h70);
        chk("wr_drop quiet", {31'b0, wr_drop}, 32'd0);

        // ---- flush on the fill completion edge ----
        ram_lat = 0;
        bus.cpu_addr = 16'h0100;                 // byte 0x80 = 0xDA
        bus.cpu_rw = 1'b1;
        @(posedge clk); #1;                      // FILL, ready this cycle
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush rd_en after fill", {31'b0, bus.cpu_rd_en}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush refetch ram_en", {31'b0, bus.ram_en}, 32'd1);
        chk("flush refetch ram_addr", {17'b0, bus.ram_addr}, 32'h0080);
        @(posedge clk); #1;
        wait_rd(c, ok);
        chk("flush refetch done", {31'b0, ok}, 32'd1);
        chk("flush refetch cycles", c, 0);
        chk("flush refetch rdata", {28'b0, bus.cpu_rdata}, 32'hA);
        @(posedge clk); #1;

        // ---- write arriving during FILL is dropped ----
        bus.cpu_addr = 16'h0202;                 // byte 0x101 = 0x5B
        @(posedge clk); #1;                      // FILL
        bus.cpu_rw = 1'b0;
        bus.cpu_wdata = 4'hF;
        @(negedge clk);
        chk("busy wr_en", {31'b0, bus.cpu_wr_en}, 32'd0);
        @(posedge clk); #1;
        bus.cpu_rw = 1'b1;
        @(negedge clk);
        chk("busy wr_drop", {31'b0, wr_drop}, 32'd1);
        chk("busy rd_en", {31'b0, bus.cpu_rd_en}, 32'd1);
        chk("busy rdata", {28'b0, bus.cpu_rdata}, 32'hB);
        chk("busy ram untouched", {24'b0, mem[15'h0101]}, 32'h5B);
        @(posedge clk); #1;

        // ---- reset in the middle of a write ----
        ram_lat = 5;
        bus.cpu_addr = 16'h0203;
        bus.cpu_rw = 1'b0;
        bus.cpu_wdata = 4'h6;                    // would give 0x6B
        @(negedge clk);
        chk("abort wr_en", {31'b0, bus.cpu_wr_en}, 32'd1);
        @(posedge clk); #1;                      // WRITE
        bus.cpu_rw = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort write in flight", {30'b0, bus.ram_en, bus.ram_we}, 32'd3);
        chk("abort rdata forced", {28'b0, bus.cpu_rdata}, 32'd0);
        chk("abort rd_en forced", {31'b0, bus.cpu_rd_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort ram_en", {31'b0, bus.ram_en}, 32'd0);
        chk("abort wr_drop", {31'b0, wr_drop}, 32'd0);
        chk("abort buffer invalid", {31'b0, bus.cpu_rd_en}, 32'd0);
        @(posedge clk); #1;
        wait_rd(c, ok);
        chk("abort refill done", {31'b0, ok}, 32'd1);
        chk("abort refill rdata", {28'b0, bus.cpu_rdata}, 32'h5);
        chk("abort ram unchanged", {24'b0, mem[15'h0101]}, 32'h5B);
        @(posedge clk); #1;

        chk("ram_addr stable", addr_glitch, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
